// File: rtl/debug_wb_master.sv
// rtl/debug_wb_master.sv - byte-stream command decoder driving single-beat Wishbone cycles
module debug_wb_master #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] RSP_WR_OK  = 8'h81;
    localparam logic [7:0] RSP_RD_OK  = 8'h82;
    localparam logic [7:0] RSP_WR_TMO = 8'hE1;
    localparam logic [7:0] RSP_RD_TMO = 8'hE2;
    localparam logic [7:0] RSP_BAD_OP = 8'hEE;

    // The counter value seen on the edge that completes the TIMEOUT-th bus cycle.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t                 state;
    logic [1:0]             byte_cnt;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic [31:0]            resp_shift;
    logic [2:0]             resp_left;
    logic                   rx_fire;
    logic                   tx_fire;

    // Accept bytes only while collecting a frame; held low throughout reset.
    assign rx_ready = !wb_rst_i &&
                      (state == S_IDLE || state == S_ADDR || state == S_DATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign busy     = (state != S_IDLE);

    // Frame decode, bus cycle sequencing and response serialisation.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            resp_shift <= '0;
            resp_left  <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= '0;
                        if (rx_data == OP_WRITE) begin
                            wb_we_o <= 1'b1;
                            state   <= S_ADDR;
                        end else if (rx_data == OP_READ) begin
                            wb_we_o <= 1'b0;
                            state   <= S_ADDR;
                        end else begin
                            tx_data   <= RSP_BAD_OP;
                            tx_valid  <= 1'b1;
                            resp_left <= '0;
                            state     <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_fire) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (wb_we_o) begin
                                state <= S_DATA;
                            end else begin
                                state    <= S_BUS;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_sel_o <= 4'hF;
                                tmo_cnt  <= '0;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (rx_fire) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= S_BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= 4'hF;
                            tmo_cnt  <= '0;
                        end
                    end
                end

                S_BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        tx_valid <= 1'b1;
                        state    <= S_RESP;
                        if (wb_we_o) begin
                            tx_data   <= RSP_WR_OK;
                            resp_left <= '0;
                        end else begin
                            tx_data    <= RSP_RD_OK;
                            resp_shift <= wb_dat_i;
                            resp_left  <= 3'd4;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= '0;
                        tx_valid  <= 1'b1;
                        tx_data   <= wb_we_o ? RSP_WR_TMO : RSP_RD_TMO;
                        resp_left <= '0;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (tx_fire) begin
                        if (resp_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            tx_data    <= resp_shift[31:24];
                            resp_shift <= {resp_shift[23:0], 8'h00};
                            resp_left  <= resp_left - 3'd1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_wb_master.sv
// tb/tb_debug_wb_master.sv - self-checking bench for debug_wb_master
module tb_debug_wb_master;

    localparam int TIMEOUT = 255;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  op;
        logic [31:0] adr;
        logic [31:0] dat;
        int          mode;
        logic [31:0] rdata;
        int          hold;
        logic [7:0]  exp_first;
        int          exp_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        busy;

    int total = 0;
    int bad = 0;

    // slave behaviour: 0 = absent, 1 = zero-wait, 2 = one wait state
    int          mode = 0;
    logic [31:0] srd = '0;
    logic        ack_reg = 1'b0;
    logic        ack_force = 1'b0;

    int          cyc_cycles = 0;
    int          viol = 0;
    int          stab_err = 0;
    int          rxr_err = 0;
    logic        mon_seen = 1'b0;
    logic [31:0] mon_adr = '0;
    logic [31:0] mon_dat = '0;
    logic        mon_we = 1'b0;

    always #5 clk = ~clk;

    debug_wb_master #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i),
        .busy     (busy)
    );

    assign wb_dat_i = srd;
    assign wb_ack_i = ack_force | ack_reg | ((mode == 1) && wb_cyc_o && wb_stb_o);

    always @(posedge clk) begin
        ack_reg <= (mode == 2) && wb_cyc_o && wb_stb_o && !ack_reg;
    end

    // Bus monitor: count cyc cycles, check qualifiers are stable while cyc is high.
    always @(negedge clk) begin
        if (wb_cyc_o) begin
            cyc_cycles++;
            if (!mon_seen) begin
                mon_seen = 1'b1;
                mon_adr  = wb_adr_o;
                mon_dat  = wb_dat_o;
                mon_we   = wb_we_o;
            end else if (wb_adr_o !== mon_adr || wb_dat_o !== mon_dat || wb_we_o !== mon_we) begin
                viol++;
            end
            if (wb_sel_o !== 4'hF || wb_stb_o !== 1'b1) viol++;
        end else if (!rst && (wb_sel_o !== 4'h0 || wb_stb_o !== 1'b0)) begin
            viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: response bytes and bus occupancy from the frame rules.
    function automatic void model(input logic [7:0] op, input int md, input logic [31:0] rd,
                                  output bq_t q, output int cyc);
        q = {};
        if (op == 8'h01) begin
            q.push_back(md == 0 ? 8'hE1 : 8'h81);
            cyc = (md == 0) ? TIMEOUT : md;
        end else if (op == 8'h02) begin
            if (md == 0) begin
                q.push_back(8'hE2);
            end else begin
                q.push_back(8'h82);
                for (int i = 3; i >= 0; i--) q.push_back(8'((rd >> (8 * i)) & 32'hFF));
            end
            cyc = (md == 0) ? TIMEOUT : md;
        end else begin
            q.push_back(8'hEE);
            cyc = 0;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input int hold, output logic [7:0] b, output logic ok);
        int n = 0;
        logic [7:0] b0;
        while (!tx_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = tx_valid;
        b  = 8'h00;
        if (!tx_valid) begin
            check("tx_valid_wait", 32'(tx_valid), 32'd1);
            return;
        end
        b0 = tx_data;
        if (rx_ready) rxr_err++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (tx_data !== b0 || tx_valid !== 1'b1) stab_err++;
            if (rx_ready) rxr_err++;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        b = b0;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                           input int md, input logic [31:0] rd, input int hold,
                           output logic [7:0] first, output int cyc_seen);
        bq_t  exp_q;
        int   exp_cyc;
        logic [7:0] b;
        logic ok;
        model(op, md, rd, exp_q, exp_cyc);
        mode = md;
        srd  = rd;
        cyc_cycles = 0;
        viol = 0;
        stab_err = 0;
        rxr_err = 0;
        mon_seen = 1'b0;
        send_byte(op);
        if (op == 8'h01 || op == 8'h02)
            for (int i = 3; i >= 0; i--) send_byte(8'((adr >> (8 * i)) & 32'hFF));
        if (op == 8'h01)
            for (int i = 3; i >= 0; i--) send_byte(8'((dat >> (8 * i)) & 32'hFF));
        first = 8'h00;
        foreach (exp_q[i]) begin
            recv_byte(hold, b, ok);
            if (!ok) break;
            if (i == 0) first = b;
            check($sformatf("resp_byte%0d_op%0h", i, op), 32'(b), 32'(exp_q[i]));
        end
        check("tx_valid_after", 32'(tx_valid), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("cyc_cycles", 32'(cyc_cycles), 32'(exp_cyc));
        check("bus_stability", 32'(viol), 32'd0);
        check("tx_hold_stable", 32'(stab_err), 32'd0);
        check("rx_ready_in_resp", 32'(rxr_err), 32'd0);
        if (exp_cyc > 0) begin
            check("bus_adr", mon_adr, adr);
            check("bus_we", 32'(mon_we), 32'(op == 8'h01));
            if (op == 8'h01) check("bus_dat", mon_dat, dat);
        end
        cyc_seen = cyc_seen + 0;
        cyc_seen = cyc_cycles;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] first;
        int         cyc;
        int         n;

        vecs[0] = '{8'h01, 32'h0000_0000, 32'h0000_0000, 2, 32'h0,         0,  8'h81, 2};
        vecs[1] = '{8'h02, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0001, 0,  8'h82, 2};
        vecs[2] = '{8'h02, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0,         0,  8'hE2, TIMEOUT};
        vecs[3] = '{8'h7F, 32'h0000_0000, 32'h0000_0000, 1, 32'h0,         0,  8'hEE, 0};
        vecs[4] = '{8'h02, 32'h1234_5678, 32'h0000_0000, 1, 32'hA5C3_0F96, 10, 8'h82, 1};
        vecs[5] = '{8'h01, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 32'h0,         1,  8'hE1, TIMEOUT};

        // reset state
        @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);

        // directed table
        for (int v = 0; v < 6; v++) begin
            cyc = 0;
            run_txn(vecs[v].op, vecs[v].adr, vecs[v].dat, vecs[v].mode, vecs[v].rdata,
                    vecs[v].hold, first, cyc);
            check($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d_cyc", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            if (v == 2) begin
                // late ack after a timeout must be ignored
                mode = 0;
                repeat (3) @(negedge clk);
                ack_force = 1'b1;
                @(negedge clk);
                ack_force = 1'b0;
                check("late_ack_cyc", 32'(wb_cyc_o), 32'd0);
                check("late_ack_tx", 32'(tx_valid), 32'd0);
                check("late_ack_busy", 32'(busy), 32'd0);
            end
        end

        // randomized frames against the model
        for (int r = 0; r < 10; r++) begin
            logic [7:0]  op;
            int          md;
            n = int'($urandom_range(0, 9));
            op = (n < 4) ? 8'h01 : (n < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            md = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2));
            cyc = 0;
            run_txn(op, $urandom, $urandom, md, $urandom, int'($urandom_range(0, 2)), first, cyc);
        end

        // reset while a read is on the bus
        mode = 0;
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        n = 0;
        while (!wb_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midbus_cyc_seen", 32'(wb_cyc_o), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cyc", 32'(wb_cyc_o), 32'd0);
        check("arst_stb", 32'(wb_stb_o), 32'd0);
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rx_ready", 32'(rx_ready), 32'd0);
        check("arst_adr", wb_adr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_tx_quiet", 32'(tx_valid), 32'd0);
        cyc = 0;
        run_txn(8'h01, 32'h0000_0010, 32'h0000_00FF, 2, 32'h0, 0, first, cyc);
        check("post_rst_first", 32'(first), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
